// File: rtl/multi_led_blinker_if.sv
// Configuration write port of the multi-channel LED blinker.
// The master presents a channel/mode/half-period write; the slave answers with ready.
interface multi_led_blinker_if #(
    parameter int CHANNELS = 4,
    parameter int HALF_W   = 16
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_mode;
    logic [HALF_W-1:0] cfg_half;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_mode,
        output cfg_half,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_mode,
        input  cfg_half,
        output cfg_ready
    );
endinterface

// File: rtl/multi_led_blinker.sv
// Multi-channel LED driver: one shared prescaler tick drives per-channel OFF/ON/BLINK/ONESHOT
// outputs, configured through a valid/ready port and realigned by a sync strobe.
module multi_led_blinker #(
    parameter int CLK_FREQ_KHz = 50000,
    parameter int TICK_FREQ_Hz = 1000,
    parameter int CHANNELS     = 4,
    parameter int HALF_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_led_blinker_if.slave    cfg,
    input  logic                  sync_in,
    output logic                  tick,
    output logic [CHANNELS-1:0]   led
);
    localparam int TICK_DIV = (CLK_FREQ_KHz * 1000) / TICK_FREQ_Hz;
    localparam int PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    logic [PRE_W-1:0]                 pre_q,  pre_d;
    logic                             tick_q, tick_d;
    logic                             ready_q, ready_d;
    logic                             accept_s;
    logic [CHANNELS-1:0][1:0]         mode_q, mode_d;
    logic [CHANNELS-1:0][HALF_W-1:0]  half_q, half_d;
    logic [CHANNELS-1:0][HALF_W-1:0]  cnt_q,  cnt_d;
    logic [CHANNELS-1:0]              led_q,  led_d;

    // Last counter value before a phase ends; a zero half-period behaves as one tick.
    function automatic logic [HALF_W-1:0] last_cnt(input logic [HALF_W-1:0] half);
        return (half == {HALF_W{1'b0}}) ? {HALF_W{1'b0}} : half - HALF_W'(1);
    endfunction

    // Prescaler and handshake next state; sync restarts the time base and hides a same-cycle wrap.
    always_comb begin
        pre_d  = pre_q;
        tick_d = 1'b0;
        if (sync_in) begin
            pre_d  = {PRE_W{1'b0}};
            tick_d = 1'b0;
        end else if (pre_q == PRE_LAST) begin
            pre_d  = {PRE_W{1'b0}};
            tick_d = 1'b1;
        end else begin
            pre_d  = pre_q + PRE_W'(1);
            tick_d = 1'b0;
        end
        accept_s = cfg.cfg_valid && ready_q;
        ready_d  = !accept_s;
    end

    // Per-channel next state: write beats sync, sync beats tick.
    always_comb begin
        mode_d = mode_q;
        half_d = half_q;
        cnt_d  = cnt_q;
        led_d  = led_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (accept_s && (int'(cfg.cfg_ch) == i)) begin
                mode_d[i] = cfg.cfg_mode;
                half_d[i] = cfg.cfg_half;
                cnt_d[i]  = {HALF_W{1'b0}};
                led_d[i]  = (cfg.cfg_mode != MODE_OFF);
            end else if (sync_in) begin
                if (mode_q[i] == MODE_BLINK) begin
                    cnt_d[i] = {HALF_W{1'b0}};
                    led_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end else if (tick_q) begin
                case (mode_q[i])
                    MODE_BLINK: begin
                        if (cnt_q[i] >= last_cnt(half_q[i])) begin
                            cnt_d[i] = {HALF_W{1'b0}};
                            led_d[i] = ~led_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + HALF_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (cnt_q[i] >= last_cnt(half_q[i])) begin
                            cnt_d[i]  = {HALF_W{1'b0}};
                            led_d[i]  = 1'b0;
                            mode_d[i] = MODE_OFF;
                        end else begin
                            cnt_d[i] = cnt_q[i] + HALF_W'(1);
                        end
                    end
                    default: begin
                        cnt_d[i] = cnt_q[i];
                    end
                endcase
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q   <= {PRE_W{1'b0}};
            tick_q  <= 1'b0;
            ready_q <= 1'b1;
            mode_q  <= {CHANNELS{2'b00}};
            half_q  <= {CHANNELS{{HALF_W{1'b0}}}};
            cnt_q   <= {CHANNELS{{HALF_W{1'b0}}}};
            led_q   <= {CHANNELS{1'b0}};
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            ready_q <= ready_d;
            mode_q  <= mode_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    assign tick          = tick_q;
    assign led           = led_q;
    assign cfg.cfg_ready = ready_q;
endmodule

// File: tb/tb_multi_led_blinker.sv
// Scoreboard bench for multi_led_blinker: TICK_DIV=10, 4 channels, plus a 3-channel copy
// used to exercise an out-of-range channel index.
module tb_multi_led_blinker;
    logic       clk = 1'b0;
    logic       rst;
    logic       sync_in;
    logic       sync2;
    logic       tick, tick2;
    logic [3:0] led;
    logic [2:0] led2;

    always #5 clk = ~clk;

    multi_led_blinker_if #(.CHANNELS(4), .HALF_W(8)) cif ();
    multi_led_blinker_if #(.CHANNELS(3), .HALF_W(8)) cif2 ();

    multi_led_blinker #(.CLK_FREQ_KHz(1), .TICK_FREQ_Hz(100), .CHANNELS(4), .HALF_W(8)) dut (
        .clk(clk), .rst(rst), .cfg(cif.slave), .sync_in(sync_in), .tick(tick), .led(led)
    );

    multi_led_blinker #(.CLK_FREQ_KHz(1), .TICK_FREQ_Hz(100), .CHANNELS(3), .HALF_W(8)) dut2 (
        .clk(clk), .rst(rst), .cfg(cif2.slave), .sync_in(sync2), .tick(tick2), .led(led2)
    );

    typedef struct {
        logic [3:0] led;
        logic       tick;
        logic       ready;
        bit         chk_tick;
        bit         chk_ready;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cif.cfg_valid  = 1'b0;
        cif.cfg_ch     = 2'd0;
        cif.cfg_mode   = 2'd0;
        cif.cfg_half   = 8'd0;
        cif2.cfg_valid = 1'b0;
        cif2.cfg_ch    = 2'd0;
        cif2.cfg_mode  = 2'd0;
        cif2.cfg_half  = 8'd0;
        sync_in        = 1'b0;
        sync2          = 1'b0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] half);
        cif.cfg_valid = 1'b1;
        cif.cfg_ch    = ch;
        cif.cfg_mode  = mode;
        cif.cfg_half  = half;
    endtask

    task automatic wr2(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] half);
        cif2.cfg_valid = 1'b1;
        cif2.cfg_ch    = ch;
        cif2.cfg_mode  = mode;
        cif2.cfg_half  = half;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        rst = 1'b0;
        for (int n = 1; n <= 33; n++) begin
            rst = (n > 3);
            e.led = 4'b0000;
            e.tick = (n > 3) && (((n - 3) % 10) == 0);
            e.ready = 1'b1;
            e.chk_tick = 1'b1;
            e.chk_ready = 1'b1;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            checks++;
            if (led !== e.led) begin errors++; $display("FAIL reset_led n=%0d got=%b exp=%b", n, led, e.led); end
            checks++;
            if (tick !== e.tick) begin errors++; $display("FAIL reset_tick n=%0d got=%b exp=%b", n, tick, e.tick); end
            checks++;
            if (cif.cfg_ready !== e.ready) begin errors++; $display("FAIL reset_ready n=%0d got=%b exp=%b", n, cif.cfg_ready, e.ready); end
        end
    endtask

    task automatic test_blink();
        exp_t e;
        do_reset();
        for (int n = 1; n <= 70; n++) begin
            idle();
            if (n == 1) wr(2'd0, 2'd2, 8'd3);
            if (n == 3) wr(2'd2, 2'd2, 8'd0);
            e.led = 4'b0000;
            e.led[0] = (((n - 1) / 30) % 2) == 0;
            e.led[2] = (n >= 3) && ((((n - 1) / 10) % 2) == 0);
            e.tick = (n % 10) == 0;
            e.ready = 1'b1;
            e.chk_tick = 1'b1;
            e.chk_ready = 1'b0;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            checks++;
            if (led !== e.led) begin errors++; $display("FAIL blink_led n=%0d got=%b exp=%b", n, led, e.led); end
            if (e.chk_tick) begin
                checks++;
                if (tick !== e.tick) begin errors++; $display("FAIL blink_tick n=%0d got=%b exp=%b", n, tick, e.tick); end
            end
        end
    endtask

    task automatic test_oneshot();
        exp_t e;
        do_reset();
        for (int n = 1; n <= 140; n++) begin
            idle();
            if (n == 1)   wr(2'd1, 2'd3, 8'd2);
            if (n == 126) wr(2'd1, 2'd1, 8'd0);
            e.led = 4'b0000;
            e.led[1] = (n <= 20) || (n >= 126);
            sb.push_back(e);
            step();
            e = sb.pop_front();
            checks++;
            if (led !== e.led) begin errors++; $display("FAIL oneshot_led n=%0d got=%b exp=%b", n, led, e.led); end
        end
    endtask

    task automatic test_handshake();
        exp_t e;
        do_reset();
        checks++;
        if (cif.cfg_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_idle got=%b exp=1", cif.cfg_ready); end
        for (int n = 1; n <= 6; n++) begin
            idle();
            if (n <= 4) wr(2'(n - 1), 2'd1, 8'd0);
            e.led = (n >= 3) ? 4'b0101 : 4'b0001;
            e.ready = !((n == 1) || (n == 3));
            sb.push_back(e);
            step();
            e = sb.pop_front();
            checks++;
            if (led !== e.led) begin errors++; $display("FAIL hs_led n=%0d got=%b exp=%b", n, led, e.led); end
            checks++;
            if (cif.cfg_ready !== e.ready) begin errors++; $display("FAIL hs_ready n=%0d got=%b exp=%b", n, cif.cfg_ready, e.ready); end
        end
    endtask

    task automatic test_out_of_range();
        exp_t e;
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            idle();
            if (n == 1) wr2(2'd3, 2'd1, 8'd0);
            if (n == 3) wr2(2'd1, 2'd1, 8'd0);
            e.led = (n >= 3) ? 4'b0010 : 4'b0000;
            e.ready = !((n == 1) || (n == 3));
            sb.push_back(e);
            step();
            e = sb.pop_front();
            checks++;
            if ({1'b0, led2} !== e.led) begin errors++; $display("FAIL oor_led n=%0d got=%b exp=%b", n, led2, e.led); end
            checks++;
            if (cif2.cfg_ready !== e.ready) begin errors++; $display("FAIL oor_ready n=%0d got=%b exp=%b", n, cif2.cfg_ready, e.ready); end
        end
    endtask

    task automatic test_sync();
        exp_t e;
        do_reset();
        for (int n = 1; n <= 130; n++) begin
            idle();
            if (n == 1)  wr(2'd0, 2'd2, 8'd3);
            if (n == 3)  wr(2'd3, 2'd2, 8'd5);
            if (n == 5)  wr(2'd1, 2'd1, 8'd0);
            if (n == 65) sync_in = 1'b1;
            e.led = 4'b0000;
            e.led[0] = (n <= 30) || ((n >= 61) && (n <= 95)) || (n >= 126);
            e.led[1] = (n >= 5);
            e.led[3] = ((n >= 3) && (n <= 50)) || ((n >= 65) && (n <= 115));
            e.tick = (n < 65) ? ((n % 10) == 0) : ((n > 65) && (((n - 65) % 10) == 0));
            sb.push_back(e);
            step();
            e = sb.pop_front();
            checks++;
            if (led !== e.led) begin errors++; $display("FAIL sync_led n=%0d got=%b exp=%b", n, led, e.led); end
            checks++;
            if (tick !== e.tick) begin errors++; $display("FAIL sync_tick n=%0d got=%b exp=%b", n, tick, e.tick); end
        end
    endtask

    task automatic test_collision();
        exp_t e;
        do_reset();
        for (int n = 1; n <= 60; n++) begin
            idle();
            rst = (n != 55);
            if (n == 1)  wr(2'd0, 2'd2, 8'd3);
            if (n == 3)  wr(2'd2, 2'd1, 8'd0);
            if (n == 20) begin sync_in = 1'b1; wr(2'd0, 2'd0, 8'd3); end
            if (n == 22) wr(2'd3, 2'd2, 8'd1);
            if (n == 31) wr(2'd3, 2'd2, 8'd1);
            if (n == 55) wr(2'd0, 2'd1, 8'd0);
            e.led = 4'b0000;
            if (n < 55) begin
                e.led[0] = (n <= 19);
                e.led[2] = (n >= 3);
                e.led[3] = ((n >= 22) && (n <= 40)) || (n >= 51);
            end
            e.tick = (n < 55) && (n != 20) && ((n % 10) == 0);
            e.ready = 1'b1;
            e.chk_ready = (n >= 55);
            sb.push_back(e);
            step();
            e = sb.pop_front();
            checks++;
            if (led !== e.led) begin errors++; $display("FAIL coll_led n=%0d got=%b exp=%b", n, led, e.led); end
            checks++;
            if (tick !== e.tick) begin errors++; $display("FAIL coll_tick n=%0d got=%b exp=%b", n, tick, e.tick); end
            if (e.chk_ready) begin
                checks++;
                if (cif.cfg_ready !== e.ready) begin errors++; $display("FAIL coll_ready n=%0d got=%b exp=%b", n, cif.cfg_ready, e.ready); end
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_blink();
        test_oneshot();
        test_handshake();
        test_out_of_range();
        test_sync();
        test_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
